sin_arg_reduce: RTL and testbench
=================================

SIN_ARG_REDUCE -- requirements
Module: sin_arg_reduce

Interface
REQ-001 Parameter MAX_ITER, default 16, is the maximum number of 2*pi subtractions allowed per operand.
REQ-002 Parameter ITER_W, default $clog2(MAX_ITER+1), is the iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when low, the FSM and all registers hold.
REQ-006 in_valid  input  1  input_data is valid.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 input_data  input  32  IEEE-754 single-precision angle in radians.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 output_data  output  32  reduced argument r, in the range [0, pi/2], single precision.
REQ-012 quadrant  output  2  quadrant index q of |x| mod 2*pi.
REQ-013 sin_neg  output  1  sin(x) = -sin(r) when high.
REQ-014 err  output  1  NaN/Inf input or iteration limit exceeded.

Function
REQ-015 The FSM states SHALL be IDLE, STRIP, FOLD and DONE.
REQ-016 in_ready = enable && state==IDLE; an operand is accepted on in_valid && in_ready, latching the magnitude m = {0, input_data[30:0]} and sign s = input_data[31], clearing the counter, and moving to STRIP.
REQ-017 STRIP: if m > TWO_PI, m <= m - TWO_PI and the counter increments; otherwise go to FOLD.
REQ-018 STRIP: if the counter reaches MAX_ITER while m > TWO_PI, set err and go to FOLD.
REQ-019 Magnitude compares SHALL be 31-bit unsigned integer compares, which are valid for non-negative floats.
REQ-020 FOLD, with the result registered and the FSM moving to DONE:
  - m <= PI_HALF: r = m, q = 0.
  - m <= PI: r = PI - m, q = 1.
  - m <= PI_3_2: r = m - PI, q = 2.
  - otherwise: r = TWO_PI - m, q = 3.
REQ-021 sin_neg = s XOR q[1].
REQ-022 An exponent of all ones (NaN or Inf) SHALL set err, force output_data = 0, q = 0 and sin_neg = 0, and bypass STRIP (IDLE -> FOLD).
REQ-023 When err is set, output_data = 0, quadrant = 0 and sin_neg = 0.
REQ-024 DONE: out_valid = 1 and all outputs are held stable until out_ready is sampled high, then the FSM returns to IDLE; in_ready stays low in DONE (no overlap).
REQ-025 Latency: out_valid rises 3 cycles after the accept edge plus 1 cycle per subtraction performed.
REQ-026 enable low in any state freezes the state, counter and outputs; handshakes are ignored.
REQ-027 Subtraction SHALL use one shared fpadd instance with control 5'b10000 (a - b, round to nearest), with operands muxed by state.

Reset
REQ-028 On reset: state = IDLE; out_valid = 0; output_data = 0; quadrant = 0; sin_neg = 0; err = 0; counter = 0.
REQ-029 Reset asserted mid-STRIP or mid-DONE aborts the operation and the result is discarded.

Configuration
REQ-030 With SIN_ARG_COS_EN defined, output port cos_neg (1 bit) = (q==1 || q==2), registered in FOLD, reset to 0, and forced to 0 on err; cos(x) = +/-cos(r).
REQ-031 Without SIN_ARG_COS_EN, the port and its logic are absent.

Structure
REQ-032 Package sin_arg_pkg SHALL hold the constants PI_HALF 32'h3FC90FDB, PI 32'h40490FDB, PI_3_2 32'h4096CBE4 and TWO_PI 32'h40C90FDB, the fpadd control codes, and the FSM state typedef.
REQ-033 The block SHALL have exactly one sub-module: the existing fpadd.

Verification
REQ-034 0x3F490FDB (pi/4) -> r = 0x3F490FDB, q = 0, sin_neg = 0, err = 0, out_valid 3 cycles after accept.
REQ-035 2.0 -> q = 1, r within 1 ulp of 1.1415927, sin_neg = 0; -4.0 -> q = 2, r within 1 ulp of 0.8584073, sin_neg = 0.
REQ-036 10.0 -> one subtraction, q = 2, r within 2 ulp of 0.5752220, sin_neg = 1, latency 4.
REQ-037 1.0e6 with MAX_ITER = 16 -> err = 1, r = 0, latency 19; 0x7FC00000 -> err = 1, r = 0.
REQ-038 out_ready held low for 5 cycles in DONE -> outputs stable, in_ready = 0; enable low for 3 cycles mid-STRIP -> latency extends by exactly 3.
REQ-039 Reset asserted in STRIP -> next cycle IDLE, out_valid = 0, in_ready = 1; next operand processed correctly.

Source files
------------

// File: rtl/sin_arg_pkg.sv
// Shared constants, fpadd control codes and FSM state type for the
// sin/cos argument-reduction block.
package sin_arg_pkg;

  localparam logic [31:0] PI_HALF = 32'h3FC90FDB;
  localparam logic [31:0] PI      = 32'h40490FDB;
  localparam logic [31:0] PI_3_2  = 32'h4096CBE4;
  localparam logic [31:0] TWO_PI  = 32'h40C90FDB;

  // fpadd control: [4] subtract b, [3] clear result sign, [2:0] rounding mode
  localparam logic [4:0] FPADD_ADD_RNE = 5'b00000;
  localparam logic [4:0] FPADD_SUB_RNE = 5'b10000;
  localparam logic [4:0] FPADD_SUB_RTZ = 5'b10001;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RUP = 3'b010;
  localparam logic [2:0] RM_RDN = 3'b011;
  localparam logic [2:0] RM_RNA = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STRIP = 2'd1,
    FOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // exponent all ones: NaN or infinity
  function automatic logic is_special(input logic [31:0] f);
    return &f[30:23];
  endfunction

endpackage

// File: rtl/sin_arg_reduce_fpadd.sv
// fpadd: combinational IEEE-754 single-precision adder/subtractor.
// Subnormal results flush to zero; NaN/Inf operands propagate.
module fpadd
  import sin_arg_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  ctrl_i,
  output logic [31:0] y_o
);

  logic               sa, sb, sl, ss;
  logic [7:0]         ea, eb, el, es, el_v, es_v, ediff;
  logic [23:0]        fa, fb, fl, fs;
  logic               a_big;
  logic [26:0]        fs_ext, fs_al, mask, norm;
  logic               sticky;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [9:0]  exp_n;
  logic               lsb, grd, rest, inexact, rnd_up;
  logic [24:0]        mant_r;
  logic [31:0]        y_raw;
  logic               a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    sa      = a_i[31];
    sb      = b_i[31] ^ ctrl_i[4];
    ea      = a_i[30:23];
    eb      = b_i[30:23];
    fa      = {|ea, a_i[22:0]};
    fb      = {|eb, b_i[22:0]};
    a_big   = a_i[30:0] >= b_i[30:0];
    sl      = a_big ? sa : sb;
    ss      = a_big ? sb : sa;
    el      = a_big ? ea : eb;
    es      = a_big ? eb : ea;
    fl      = a_big ? fa : fb;
    fs      = a_big ? fb : fa;
    el_v    = (el == 8'd0) ? 8'd1 : el;
    es_v    = (es == 8'd0) ? 8'd1 : es;
    ediff   = el_v - es_v;
    fs_ext  = {fs, 3'b000};
    mask    = '0;
    sticky  = 1'b0;
    fs_al   = '0;
    sum     = '0;
    lz      = '0;
    norm    = '0;
    exp_n   = $signed({2'b00, el_v});
    lsb     = 1'b0;
    grd     = 1'b0;
    rest    = 1'b0;
    inexact = 1'b0;
    rnd_up  = 1'b0;
    mant_r  = '0;
    y_raw   = '0;

    // align the smaller operand, folding shifted-out bits into a sticky LSB
    if (ediff > 8'd26) begin
      fs_al = {26'd0, |fs};
    end else begin
      mask   = (27'd1 << ediff) - 27'd1;
      sticky = |(fs_ext & mask);
      fs_al  = (fs_ext >> ediff) | {26'd0, sticky};
    end

    if (sl == ss) sum = {1'b0, fl, 3'b000} + {1'b0, fs_al};
    else          sum = {1'b0, fl, 3'b000} - {1'b0, fs_al};

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = exp_n + 10'sd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      norm  = sum[26:0] << lz;
      exp_n = exp_n - $signed({5'd0, lz});
    end

    lsb     = norm[3];
    grd     = norm[2];
    rest    = norm[1] | norm[0];
    inexact = grd | rest;
    case (ctrl_i[2:0])
      RM_RNE:  rnd_up = grd & (rest | lsb);
      RM_RTZ:  rnd_up = 1'b0;
      RM_RUP:  rnd_up = inexact & ~sl;
      RM_RDN:  rnd_up = inexact & sl;
      RM_RNA:  rnd_up = grd;
      default: rnd_up = 1'b0;
    endcase

    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      exp_n  = exp_n + 10'sd1;
    end

    if (sum == 28'd0)             y_raw = 32'd0;
    else if (exp_n <= 10'sd0)     y_raw = {sl, 31'd0};
    else if (exp_n >= 10'sd255)   y_raw = {sl, 8'hFF, 23'd0};
    else                          y_raw = {sl, exp_n[7:0], mant_r[22:0]};

    a_nan = is_special(a_i) & (|a_i[22:0]);
    b_nan = is_special(b_i) & (|b_i[22:0]);
    a_inf = is_special(a_i) & ~(|a_i[22:0]);
    b_inf = is_special(b_i) & ~(|b_i[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y_raw = 32'h7FC00000;
    else if (a_inf)                                       y_raw = {sa, 8'hFF, 23'd0};
    else if (b_inf)                                       y_raw = {sb, 8'hFF, 23'd0};

    y_o = ctrl_i[3] ? {1'b0, y_raw[30:0]} : y_raw;
  end

endmodule

// File: rtl/sin_arg_reduce.sv
// Reduces a float angle to r in [0, pi/2] with quadrant and sign flags.
// Define SIN_ARG_COS_EN to add the cos_neg output.
//
// state | meaning
// IDLE  | waiting for an operand (in_ready high)
// STRIP | subtracting 2*pi until m <= 2*pi or iteration limit
// FOLD  | folding m into [0, pi/2], registering r/quadrant/flags
// DONE  | result presented until out_ready
module sin_arg_reduce
  import sin_arg_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_data,
  output logic [1:0]  quadrant,
  output logic        sin_neg,
  output logic        err
`ifdef SIN_ARG_COS_EN
  ,
  output logic        cos_neg
`endif
);

  state_e              state_q, state_d;
  logic [30:0]         m_q, m_d;
  logic                sign_q, sign_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         r_q, r_d;
  logic [1:0]          quad_q, quad_d;
  logic                sin_neg_q, sin_neg_d;
  logic                err_q, err_d;
  logic [31:0]         fp_a, fp_b, fp_y;
  logic                m_gt_half, m_gt_pi, m_gt_3_2, m_gt_2pi;
  logic [1:0]          fold_q;
`ifdef SIN_ARG_COS_EN
  logic                cos_neg_q, cos_neg_d;
`endif

  fpadd u_fpadd (
    .a_i    (fp_a),
    .b_i    (fp_b),
    .ctrl_i (FPADD_SUB_RNE),
    .y_o    (fp_y)
  );

  // non-negative floats order the same as their bit patterns
  assign m_gt_half = m_q > PI_HALF[30:0];
  assign m_gt_pi   = m_q > PI[30:0];
  assign m_gt_3_2  = m_q > PI_3_2[30:0];
  assign m_gt_2pi  = m_q > TWO_PI[30:0];

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    quad_d    = quad_q;
    sin_neg_d = sin_neg_q;
    err_d     = err_q;
    fp_a      = {1'b0, m_q};
    fp_b      = TWO_PI;
    fold_q    = 2'd0;
`ifdef SIN_ARG_COS_EN
    cos_neg_d = cos_neg_q;
`endif

    if (!m_gt_half)     fold_q = 2'd0;
    else if (!m_gt_pi)  fold_q = 2'd1;
    else if (!m_gt_3_2) fold_q = 2'd2;
    else                fold_q = 2'd3;

    if (state_q == FOLD) begin
      case (fold_q)
        2'd1:    begin fp_a = PI;                 fp_b = {1'b0, m_q}; end
        2'd2:    begin fp_a = {1'b0, m_q};        fp_b = PI;          end
        2'd3:    begin fp_a = TWO_PI;             fp_b = {1'b0, m_q}; end
        default: begin fp_a = {1'b0, m_q};        fp_b = TWO_PI;      end
      endcase
    end

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_d     = input_data[30:0];
            sign_d  = input_data[31];
            cnt_d   = '0;
            err_d   = is_special(input_data);
            state_d = is_special(input_data) ? FOLD : STRIP;
          end
        end
        STRIP: begin
          if (m_gt_2pi) begin
            if (cnt_q == ITER_W'(MAX_ITER)) begin
              err_d   = 1'b1;
              state_d = FOLD;
            end else begin
              m_d   = fp_y[30:0];
              cnt_d = cnt_q + ITER_W'(1);
            end
          end else begin
            state_d = FOLD;
          end
        end
        FOLD: begin
          if (err_q) begin
            r_d       = 32'd0;
            quad_d    = 2'd0;
            sin_neg_d = 1'b0;
`ifdef SIN_ARG_COS_EN
            cos_neg_d = 1'b0;
`endif
          end else begin
            r_d       = (fold_q == 2'd0) ? {1'b0, m_q} : fp_y;
            quad_d    = fold_q;
            sin_neg_d = sign_q ^ fold_q[1];
`ifdef SIN_ARG_COS_EN
            cos_neg_d = (fold_q == 2'd1) || (fold_q == 2'd2);
`endif
          end
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      r_q       <= '0;
      quad_q    <= '0;
      sin_neg_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SIN_ARG_COS_EN
      cos_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      quad_q    <= quad_d;
      sin_neg_q <= sin_neg_d;
      err_q     <= err_d;
`ifdef SIN_ARG_COS_EN
      cos_neg_q <= cos_neg_d;
`endif
    end
  end

  assign in_ready    = enable && (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign output_data = r_q;
  assign quadrant    = quad_q;
  assign sin_neg     = sin_neg_q;
  assign err         = err_q;
`ifdef SIN_ARG_COS_EN
  assign cos_neg     = cos_neg_q;
`endif

endmodule

// File: tb/tb_sin_arg_reduce.sv
// Randomized bench for sin_arg_reduce against a real-arithmetic reference
// model that rounds each single-precision step to nearest-even.
module tb_sin_arg_reduce;

  localparam int MAX_ITER = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] input_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] output_data;
  logic [1:0]  quadrant;
  logic        sin_neg;
  logic        err;
`ifdef SIN_ARG_COS_EN
  logic        cos_neg;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  sin_arg_reduce #(.MAX_ITER(MAX_ITER)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_data  (input_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data),
    .quadrant    (quadrant),
    .sin_neg     (sin_neg),
    .err         (err)
`ifdef SIN_ARG_COS_EN
    ,
    .cos_neg     (cos_neg)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) repeat (k) p = p * 2.0;
    else        repeat (-k) p = p / 2.0;
    return p;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    int e = int'(f[30:23]);
    real man = real'(int'(f[22:0]));
    if (e == 0) return man * pow2(-149);
    return (8388608.0 + man) * pow2(e - 150);
  endfunction

  // non-negative real -> single bits, round to nearest even
  function automatic logic [31:0] r2f(input real v);
    real x, fr, ip, rem;
    int e, be;
    logic [23:0] mi;
    if (v <= 0.0) return 32'd0;
    x = v; e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    be = e + 127;
    if (be <= 0) return 32'd0;
    fr  = (x - 1.0) * 8388608.0;
    ip  = $floor(fr);
    rem = fr - ip;
    mi  = 24'(longint'(ip));
    if (rem > 0.5 || (rem == 0.5 && mi[0])) mi = mi + 24'd1;
    if (mi[23]) begin mi = '0; be++; end
    return {1'b0, be[7:0], mi[22:0]};
  endfunction

  task automatic ref_model(input logic [31:0] x, output logic [31:0] r, output logic [1:0] q,
                           output logic neg, output logic e, output int lat);
    real two_pi_r = f2r(32'h40C90FDB);
    real pi_r     = f2r(32'h40490FDB);
    real half_r   = f2r(32'h3FC90FDB);
    real p32_r    = f2r(32'h4096CBE4);
    logic [31:0] mb;
    real m;
    int n = 0;
    r = 0; q = 0; neg = 0; e = 0;
    if (&x[30:23]) begin e = 1; lat = 2; return; end
    mb = {1'b0, x[30:0]};
    m  = f2r(mb);
    while (m > two_pi_r) begin
      if (n == MAX_ITER) begin e = 1; break; end
      mb = r2f(m - two_pi_r);
      m  = f2r(mb);
      n++;
    end
    lat = 3 + n;
    if (e) return;
    if (m <= half_r)     begin q = 0; r = mb; end
    else if (m <= pi_r)  begin q = 1; r = r2f(pi_r - m); end
    else if (m <= p32_r) begin q = 2; r = r2f(m - pi_r); end
    else                 begin q = 3; r = r2f(two_pi_r - m); end
    neg = x[31] ^ q[1];
  endtask

  task automatic run_op(input logic [31:0] x, input int gap, input int stall, input string tag,
                        output logic [31:0] r_o, output logic [1:0] q_o, output logic neg_o,
                        output logic err_o, output int lat_o);
    logic [31:0] er;
    logic [1:0]  eq;
    logic        en, ee;
    int          el, acc;
    bit          seen, stable;
    ref_model(x, er, eq, en, ee, el);
    el = el + gap;
    r_o = '0; q_o = '0; neg_o = 0; err_o = 0; lat_o = 0;
    @(negedge clk);
    input_data = x;
    in_valid   = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (in_ready) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin chk({tag, "_accept_timeout"}, 32'd0, 32'd1); in_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc = cyc;
    if (gap > 0) begin
      enable = 1'b0;
      repeat (gap) @(negedge clk);
      enable = 1'b1;
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (out_valid) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin chk({tag, "_done_timeout"}, 32'd0, 32'd1); return; end
    lat_o = cyc + 1 - acc;
    r_o = output_data; q_o = quadrant; neg_o = sin_neg; err_o = err;
    chk({tag, "_r"},   output_data, er);
    chk({tag, "_q"},   32'(quadrant), 32'(eq));
    chk({tag, "_neg"}, 32'(sin_neg), 32'(en));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_lat"}, 32'(lat_o), 32'(el));
    stable = 1;
    repeat (stall) begin
      @(negedge clk);
      if (output_data !== r_o || quadrant !== q_o || sin_neg !== neg_o || err !== err_o ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
    end
    if (stall > 0) chk({tag, "_hold"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  q;
    logic        ng, e;
    int          lat;
    real         rr;
    logic [31:0] x;
    int          ex;

    repeat (3) @(negedge clk);
    chk("rst_state", {27'd0, out_valid, sin_neg, err, quadrant}, 32'd0);
    chk("rst_data", output_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    run_op(32'h3F490FDB, 0, 0, "pi4", r, q, ng, e, lat);
    chk("pi4_lit_r", r, 32'h3F490FDB);
    chk("pi4_lit_lat", 32'(lat), 32'd3);

    run_op(32'h40000000, 0, 5, "two", r, q, ng, e, lat);
    rr = f2r(r);
    chk("two_lit_q", 32'(q), 32'd1);
    chk("two_tol", 32'((rr - 1.1415927 < 1.2e-7) && (1.1415927 - rr < 1.2e-7)), 32'd1);

    run_op(32'hC0800000, 0, 0, "m4", r, q, ng, e, lat);
    rr = f2r(r);
    chk("m4_lit_q", {30'd0, q}, {30'd0, 2'd2} | {31'd0, ng});
    chk("m4_tol", 32'((rr - 0.8584073 < 6.0e-8) && (0.8584073 - rr < 6.0e-8)), 32'd1);

    run_op(32'h41200000, 0, 0, "ten", r, q, ng, e, lat);
    chk("ten_lit", {29'd0, q, ng}, {29'd0, 2'd2, 1'b1});
    chk("ten_lit_lat", 32'(lat), 32'd4);

    run_op(32'h41200000, 3, 0, "ten_gap", r, q, ng, e, lat);
    chk("ten_gap_lat", 32'(lat), 32'd7);

    run_op(32'h49742400, 0, 0, "big", r, q, ng, e, lat);
    chk("big_lit", {r[30:0], e}, 32'd1);
    chk("big_lit_lat", 32'(lat), 32'd19);

    run_op(32'h7FC00000, 0, 0, "nan", r, q, ng, e, lat);
    chk("nan_lit", {r[30:0], e}, 32'd1);

    // abort a long reduction partway through STRIP
    @(negedge clk);
    input_data = 32'h49742400;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {30'd0, out_valid, in_ready}, 32'b01);
    reset = 1'b0;
    run_op(32'h3F490FDB, 0, 0, "post_abort", r, q, ng, e, lat);

    for (int k = 0; k < 40; k++) begin
      ex = int'($urandom_range(0, 9));
      if (ex == 0)      ex = 255;
      else if (ex == 1) ex = 0;
      else              ex = int'($urandom_range(100, 135));
      x = {1'($urandom), ex[7:0], 23'($urandom)};
      run_op(x, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $sformatf("rnd%0d", k),
             r, q, ng, e, lat);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
